// File: rtl/lcd_resp_pkg.sv
// Shared types and constants for the HD44780-style LCD responder.
// The optional display-shift feature is selected with LCD_RESP_SHIFT_EN.
package lcd_resp_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, EXEC} state_e;

  typedef enum logic [3:0] {
    INS_NOP, INS_CLEAR, INS_HOME, INS_ENTRY, INS_DISP,
    INS_SHIFT, INS_FUNC, INS_CGRAM, INS_DDRAM
  } instr_e;

  localparam int DDRAM_DEPTH = 128;
  localparam int AC_W        = 7;

  localparam logic RS_INSTR = 1'b0;
  localparam logic RS_DATA  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [7:0] MASK_DDRAM = 8'h80, VAL_DDRAM = 8'h80;
  localparam logic [7:0] MASK_CGRAM = 8'hC0, VAL_CGRAM = 8'h40;
  localparam logic [7:0] MASK_FUNC  = 8'hE0, VAL_FUNC  = 8'h20;
  localparam logic [7:0] MASK_SHIFT = 8'hF0, VAL_SHIFT = 8'h10;
  localparam logic [7:0] MASK_DISP  = 8'hF8, VAL_DISP  = 8'h08;
  localparam logic [7:0] MASK_ENTRY = 8'hFC, VAL_ENTRY = 8'h04;
  localparam logic [7:0] MASK_HOME  = 8'hFE, VAL_HOME  = 8'h02;
  localparam logic [7:0] VAL_CLEAR  = 8'h01;

  // Instruction class is chosen by the highest set bit of the command byte.
  function automatic instr_e decode_instr(input logic [7:0] d);
    instr_e r;
    r = INS_NOP;
    if ((d & MASK_DDRAM) == VAL_DDRAM)      r = INS_DDRAM;
    else if ((d & MASK_CGRAM) == VAL_CGRAM) r = INS_CGRAM;
    else if ((d & MASK_FUNC) == VAL_FUNC)   r = INS_FUNC;
    else if ((d & MASK_SHIFT) == VAL_SHIFT) r = INS_SHIFT;
    else if ((d & MASK_DISP) == VAL_DISP)   r = INS_DISP;
    else if ((d & MASK_ENTRY) == VAL_ENTRY) r = INS_ENTRY;
    else if ((d & MASK_HOME) == VAL_HOME)   r = INS_HOME;
    else if (d == VAL_CLEAR)                r = INS_CLEAR;
    return r;
  endfunction

endpackage

// File: rtl/lcd_resp_if.sv
// LCD bus between the controller (master) and the responder (slave).
interface lcd_resp_if;
  logic [7:0] lcd_data_i;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data_o;
  logic       lcd_data_oe;

  modport master (output lcd_data_i, lcd_rs, lcd_rw, lcd_en,
                  input  lcd_data_o, lcd_data_oe);
  modport slave  (input  lcd_data_i, lcd_rs, lcd_rw, lcd_en,
                  output lcd_data_o, lcd_data_oe);
endinterface

// File: rtl/lcd_resp_ddram.sv
// 128x8 display RAM: one write port, registered bus and scan read ports.
module lcd_resp_ddram import lcd_resp_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AC_W-1:0] wr_addr,
  input  logic [7:0]      wr_data,
  input  logic            bus_re,
  input  logic [AC_W-1:0] bus_addr,
  output logic [7:0]      bus_data,
  input  logic [AC_W-1:0] scan_addr,
  output logic [7:0]      scan_data
);

  logic [7:0] mem [DDRAM_DEPTH];

  // Storage is deliberately left unreset so a reset does not wipe the display.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Bus read port holds its value while the controller is not strobing.
  always_ff @(posedge clk) begin
    if (bus_re) bus_data <= mem[bus_addr];
  end

  // Scan port reads the pre-write value when both hit the same address.
  always_ff @(posedge clk) begin
    if (!rst) scan_data <= '0;
    else      scan_data <= mem[scan_addr];
  end

endmodule

// File: rtl/lcd_char_responder.sv
// Device-side HD44780-style responder: decodes commands, keeps AC, flags and
// DDRAM, and answers busy/data reads. Define LCD_RESP_SHIFT_EN to enable the
// display shift offset; otherwise disp_ofs stays 0 and S has no effect.
module lcd_char_responder import lcd_resp_pkg::*; #(
  parameter int         BUSY_CYCLES = 2000,
  parameter logic [7:0] CLEAR_FILL  = 8'h20
) (
  input  logic            clk,
  input  logic            rst,
  lcd_resp_if.slave       bus,
  input  logic            lcd_on,
  input  logic [AC_W-1:0] scan_addr,
  output logic [7:0]      scan_data,
  output logic            busy,
  output logic [AC_W-1:0] ac,
  output logic            disp_vis,
  output logic            cursor_on,
  output logic            blink_on,
  output logic            inc_mode,
  output logic            two_line,
  output logic [AC_W-1:0] disp_ofs,
  output logic            cmd_err
);

`ifdef LCD_RESP_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  localparam int CNT_W = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [AC_W-1:0]  CLR_LAST  = AC_W'(DDRAM_DEPTH - 1);

  state_e           state;
  logic [CNT_W-1:0] busy_cnt;
  logic [AC_W-1:0]  clr_cnt, ofs_q, ac_step, scan_idx, ram_addr;
  logic             en_q, rs_q, rw_q, sel_q;
  logic [7:0]       data_q, status_q, ram_wdata, ram_bus_data;
  logic             id_flag, s_flag, d_flag, c_flag, b_flag, dl_flag, n_flag;
  logic             fall, wr_strobe, rd_strobe, data_wr, ram_we;
  instr_e           instr;
  logic             unused_dl;

  assign fall      = en_q & ~bus.lcd_en;
  assign wr_strobe = fall & (rw_q == RW_WRITE);
  assign rd_strobe = fall & (rw_q == RW_READ) & (rs_q == RS_DATA);
  assign instr     = decode_instr(data_q);
  assign ac_step   = id_flag ? ac + AC_W'(1) : ac - AC_W'(1);
  assign data_wr   = wr_strobe & ~busy & (rs_q == RS_DATA);
  assign ram_we    = rst & ((state == CLEAR) | data_wr);
  assign ram_addr  = (state == CLEAR) ? clr_cnt : ac;
  assign ram_wdata = (state == CLEAR) ? CLEAR_FILL : data_q;
  assign disp_ofs  = SHIFT_EN ? ofs_q : '0;
  assign scan_idx  = scan_addr + disp_ofs;
  assign unused_dl = dl_flag;

  assign disp_vis  = lcd_on & d_flag;
  assign cursor_on = c_flag;
  assign blink_on  = b_flag;
  assign inc_mode  = id_flag;
  assign two_line  = n_flag;

  assign bus.lcd_data_oe = bus.lcd_en & (bus.lcd_rw == RW_READ);
  assign bus.lcd_data_o  = sel_q ? ram_bus_data : status_q;

  // Bus fields are delayed one cycle so they line up with the falling strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q   <= 1'b0;
      rs_q   <= RS_INSTR;
      rw_q   <= RW_WRITE;
      data_q <= '0;
    end else begin
      en_q   <= bus.lcd_en;
      rs_q   <= bus.lcd_rs;
      rw_q   <= bus.lcd_rw;
      data_q <= bus.lcd_data_i;
    end
  end

  // Read data is refreshed every cycle the strobe is high and held otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_q    <= 1'b0;
      status_q <= '0;
    end else if (bus.lcd_en) begin
      sel_q    <= (bus.lcd_rs == RS_DATA);
      status_q <= {busy, ac};
    end
  end

  // Command FSM: accepts writes when idle, runs the clear fill, times busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      busy_cnt <= '0;
      clr_cnt  <= '0;
      ac       <= '0;
      ofs_q    <= '0;
      id_flag  <= 1'b1;
      s_flag   <= 1'b0;
      d_flag   <= 1'b0;
      c_flag   <= 1'b0;
      b_flag   <= 1'b0;
      dl_flag  <= 1'b1;
      n_flag   <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_strobe) begin
            busy     <= 1'b1;
            busy_cnt <= '0;
            state    <= EXEC;
            if (rs_q == RS_DATA) begin
              ac <= ac_step;
              if (SHIFT_EN && s_flag)
                ofs_q <= id_flag ? ofs_q + AC_W'(1) : ofs_q - AC_W'(1);
            end else begin
              case (instr)
                INS_DDRAM: ac <= data_q[AC_W-1:0];
                INS_CGRAM: cmd_err <= 1'b1;
                INS_FUNC: begin
                  dl_flag <= data_q[4];
                  n_flag  <= data_q[3];
                end
                INS_SHIFT: begin
                  if (!data_q[3])
                    ac <= data_q[2] ? ac + AC_W'(1) : ac - AC_W'(1);
                  else if (SHIFT_EN)
                    ofs_q <= data_q[2] ? ofs_q - AC_W'(1) : ofs_q + AC_W'(1);
                end
                INS_DISP: begin
                  d_flag <= data_q[2];
                  c_flag <= data_q[1];
                  b_flag <= data_q[0];
                end
                INS_ENTRY: begin
                  id_flag <= data_q[1];
                  s_flag  <= data_q[0];
                end
                INS_HOME: begin
                  ac    <= '0;
                  ofs_q <= '0;
                end
                INS_CLEAR: begin
                  state   <= CLEAR;
                  clr_cnt <= '0;
                end
                default: ;
              endcase
            end
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + AC_W'(1);
          if (clr_cnt == CLR_LAST) begin
            state    <= EXEC;
            busy_cnt <= '0;
            ac       <= '0;
            id_flag  <= 1'b1;
            ofs_q    <= '0;
          end
        end
        EXEC: begin
          busy_cnt <= busy_cnt + CNT_W'(1);
          if (busy_cnt == BUSY_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (wr_strobe && busy) cmd_err <= 1'b1;
      if (rd_strobe) begin
        if (busy) cmd_err <= 1'b1;
        else      ac      <= ac_step;
      end
    end
  end

  lcd_resp_ddram u_ddram (
    .clk       (clk),
    .rst       (rst),
    .we        (ram_we),
    .wr_addr   (ram_addr),
    .wr_data   (ram_wdata),
    .bus_re    (bus.lcd_en),
    .bus_addr  (ac),
    .bus_data  (ram_bus_data),
    .scan_addr (scan_idx),
    .scan_data (scan_data)
  );

endmodule

// File: tb/tb_lcd_char_responder.sv
// Self-checking bench for lcd_char_responder with a reference model and
// expected-value queues. Honours LCD_RESP_SHIFT_EN when defined.
module tb_lcd_char_responder;
  import lcd_resp_pkg::*;

  localparam int         BUSY = 16;
  localparam logic [7:0] FILL = 8'h20;
`ifdef LCD_RESP_SHIFT_EN
  localparam bit SHIFT = 1'b1;
`else
  localparam bit SHIFT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lcd_on = 1'b0;
  logic [6:0] scan_addr = '0;
  logic [7:0] scan_data;
  logic       busy, disp_vis, cursor_on, blink_on, inc_mode, two_line, cmd_err;
  logic [6:0] ac, disp_ofs;

  lcd_resp_if bus_if ();

  lcd_char_responder #(.BUSY_CYCLES(BUSY), .CLEAR_FILL(FILL)) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .lcd_on(lcd_on),
    .scan_addr(scan_addr), .scan_data(scan_data), .busy(busy), .ac(ac),
    .disp_vis(disp_vis), .cursor_on(cursor_on), .blink_on(blink_on),
    .inc_mode(inc_mode), .two_line(two_line), .disp_ofs(disp_ofs),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] m_ram [128];
  logic [6:0] m_ac, m_ofs;
  bit         m_id, m_s, m_d, m_c, m_b, m_n;
  logic [7:0] exp_q [$];
  int         len_q [$];

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_ac = '0; m_ofs = '0; m_id = 1; m_s = 0; m_d = 0; m_c = 0; m_b = 0; m_n = 0;
  endtask

  task automatic model_write(input bit rs, input logic [7:0] d);
    if (rs) begin
      m_ram[m_ac] = d;
      if (SHIFT && m_s) m_ofs = m_id ? m_ofs + 7'd1 : m_ofs - 7'd1;
      m_ac = m_id ? m_ac + 7'd1 : m_ac - 7'd1;
    end else begin
      casez (d)
        8'b1???????: m_ac = d[6:0];
        8'b01??????: ;
        8'b001?????: m_n = d[3];
        8'b0001????: begin
          if (!d[3]) m_ac = d[2] ? m_ac + 7'd1 : m_ac - 7'd1;
          else if (SHIFT) m_ofs = d[2] ? m_ofs - 7'd1 : m_ofs + 7'd1;
        end
        8'b00001???: begin m_d = d[2]; m_c = d[1]; m_b = d[0]; end
        8'b000001??: begin m_id = d[1]; m_s = d[0]; end
        8'b0000001?: begin m_ac = '0; m_ofs = '0; end
        8'b00000001: begin
          for (int i = 0; i < 128; i++) m_ram[i] = FILL;
          m_ac = '0; m_id = 1; m_ofs = '0;
        end
        default: ;
      endcase
    end
  endtask

  // Write cycle; returns at the cycle after the strobe falls.
  task automatic bus_write(input bit rs, input logic [7:0] d, output logic err);
    @(posedge clk); #1;
    bus_if.lcd_rs = rs; bus_if.lcd_rw = 1'b0; bus_if.lcd_data_i = d; bus_if.lcd_en = 1'b1;
    cycle();
    bus_if.lcd_en = 1'b0;
    cycle();
    err = cmd_err;
  endtask

  task automatic bus_read(input bit rs, output logic [7:0] data, output logic oe,
                          output logic err);
    @(posedge clk); #1;
    bus_if.lcd_rs = rs; bus_if.lcd_rw = 1'b1; bus_if.lcd_en = 1'b1;
    cycle();
    data = bus_if.lcd_data_o;
    oe   = bus_if.lcd_data_oe;
    bus_if.lcd_en = 1'b0;
    cycle();
    err = cmd_err;
    bus_if.lcd_rw = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      n++;
      cycle();
    end
    if (busy !== 1'b0) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic command(input bit rs, input logic [7:0] d, output logic err, output int n);
    bus_write(rs, d, err);
    model_write(rs, d);
    wait_idle(BUSY + 200, n);
  endtask

  task automatic scan_all(input string name);
    logic [7:0] e;
    for (int i = 0; i < 128; i++) begin
      exp_q.push_back(m_ram[7'(i) + m_ofs]);
      scan_addr = 7'(i);
      cycle();
      e = exp_q.pop_front();
      tests_run++;
      if (scan_data !== e) begin
        tests_failed++;
        $display("[TB] FAIL %s[%0d]: got %h required %h", name, i, scan_data, e);
      end
    end
  endtask

  task automatic test_reset();
    logic [20:0] obs, exp;
    rst = 1'b0;
    repeat (3) cycle();
    model_reset();
    obs = {busy, ac, inc_mode, disp_vis, cursor_on, blink_on, two_line, disp_ofs, cmd_err};
    exp = {1'b0, m_ac, m_id, 1'b0, m_c, m_b, m_n, m_ofs, 1'b0};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %h required %h", obs, exp);
    end
    tests_run++;
    if ({bus_if.lcd_data_o, bus_if.lcd_data_oe} !== 9'h000) begin
      tests_failed++;
      $display("[TB] FAIL reset_bus: got %h required 000", {bus_if.lcd_data_o, bus_if.lcd_data_oe});
    end
    tests_run++;
    if (scan_data !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_scan: got %h required 00", scan_data);
    end
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_init();
    logic [7:0] seq [5];
    logic       err;
    int         n, e;
    seq = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
    lcd_on = 1'b1;
    foreach (seq[k]) begin
      len_q.push_back((seq[k] == 8'h01) ? 128 + BUSY : BUSY);
      command(1'b0, seq[k], err, n);
      e = len_q.pop_front();
      tests_run++;
      if (n !== e || err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL init_busy_%h: got len %0d err %b required len %0d err 0", seq[k], n, err, e);
      end
    end
    tests_run++;
    if ({two_line, disp_vis, cursor_on, blink_on, inc_mode, ac} !==
        {m_n, m_d, m_c, m_b, m_id, m_ac}) begin
      tests_failed++;
      $display("[TB] FAIL init_flags: got %b required %b",
               {two_line, disp_vis, cursor_on, blink_on, inc_mode, ac},
               {m_n, m_d, m_c, m_b, m_id, m_ac});
    end
    scan_all("init_ddram");
  endtask

  task automatic test_data_write();
    logic err;
    int   n;
    command(1'b0, 8'h80, err, n);
    command(1'b1, 8'h48, err, n);
    command(1'b1, 8'h49, err, n);
    tests_run++;
    if (ac !== m_ac || n !== BUSY) begin
      tests_failed++;
      $display("[TB] FAIL hi_write: got ac %h len %0d required ac %h len %0d", ac, n, m_ac, BUSY);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(m_ram[7'(i) + m_ofs]);
      scan_addr = 7'(i);
      cycle();
      tests_run++;
      if (scan_data !== exp_q[0]) begin
        tests_failed++;
        $display("[TB] FAIL hi_scan%0d: got %h required %h", i, scan_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_wrap();
    logic err;
    int   n;
    command(1'b0, 8'hFF, err, n);
    tests_run++;
    if (ac !== m_ac) begin
      tests_failed++; $display("[TB] FAIL wrap_set: got ac %h required %h", ac, m_ac);
    end
    command(1'b1, 8'h41, err, n);
    tests_run++;
    if (ac !== m_ac) begin
      tests_failed++; $display("[TB] FAIL wrap_up: got ac %h required %h", ac, m_ac);
    end
    command(1'b0, 8'h04, err, n);
    command(1'b1, 8'h42, err, n);
    tests_run++;
    if (ac !== m_ac || inc_mode !== m_id) begin
      tests_failed++;
      $display("[TB] FAIL wrap_down: got ac %h id %b required %h %b", ac, inc_mode, m_ac, m_id);
    end
    scan_all("wrap_ddram");
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       oe, err;
    int         n;
    bus_write(1'b0, 8'h06, err);
    model_write(1'b0, 8'h06);
    exp_q.push_back({1'b1, m_ac});
    bus_read(1'b0, d, oe, err);
    tests_run++;
    if (d !== exp_q[0] || oe !== 1'b1 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL busy_status_read: got %h oe %b err %b required %h 1 0", d, oe, err, exp_q[0]);
    end
    void'(exp_q.pop_front());
    bus_write(1'b1, 8'h55, err);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL busy_write_err: got %b required 1", err);
    end
    cycle();
    tests_run++;
    if (cmd_err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL busy_err_pulse: got %b required 0", cmd_err);
    end
    wait_idle(BUSY + 10, n);
    tests_run++;
    if (ac !== m_ac) begin
      tests_failed++; $display("[TB] FAIL busy_write_ac: got %h required %h", ac, m_ac);
    end
    exp_q.push_back({1'b0, m_ac});
    bus_read(1'b0, d, oe, err);
    tests_run++;
    if (d !== exp_q[0]) begin
      tests_failed++; $display("[TB] FAIL idle_status_read: got %h required %h", d, exp_q[0]);
    end
    void'(exp_q.pop_front());
    scan_all("busy_write_ddram");
  endtask

  task automatic test_data_read();
    logic [7:0] d;
    logic       oe, err;
    int         n;
    command(1'b0, 8'h81, err, n);
    exp_q.push_back(m_ram[m_ac]);
    m_ac = m_id ? m_ac + 7'd1 : m_ac - 7'd1;
    bus_read(1'b1, d, oe, err);
    tests_run++;
    if (d !== exp_q[0] || err !== 1'b0 || ac !== m_ac) begin
      tests_failed++;
      $display("[TB] FAIL data_read: got %h err %b ac %h required %h 0 %h", d, err, ac, exp_q[0], m_ac);
    end
    void'(exp_q.pop_front());
    command(1'b0, 8'h40, err, n);
    tests_run++;
    if (err !== 1'b1 || ac !== m_ac || n !== BUSY) begin
      tests_failed++;
      $display("[TB] FAIL cgram_reject: got err %b ac %h len %0d required 1 %h %0d", err, ac, n, m_ac, BUSY);
    end
  endtask

  task automatic test_cursor_move();
    logic [7:0] cmds [3];
    logic       err;
    int         n;
    cmds = '{8'h14, 8'h10, 8'h00};
    foreach (cmds[k]) begin
      command(1'b0, cmds[k], err, n);
      tests_run++;
      if (ac !== m_ac || n !== BUSY || err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL cursor_%h: got ac %h len %0d err %b required %h %0d 0", cmds[k], ac, n, err, m_ac, BUSY);
      end
    end
  endtask

  task automatic test_shift();
    logic [7:0] cmds [6];
    logic [1:0] rss [6];
    logic       err;
    int         n;
    cmds = '{8'h18, 8'h1C, 8'h05, 8'h5A, 8'h06, 8'h02};
    rss  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
    foreach (cmds[k]) begin
      command(rss[k][0], cmds[k], err, n);
      tests_run++;
      if (disp_ofs !== m_ofs || ac !== m_ac || n !== BUSY) begin
        tests_failed++;
        $display("[TB] FAIL shift_%h: got ofs %h ac %h len %0d required %h %h %0d", cmds[k], disp_ofs, ac, n, m_ofs, m_ac, BUSY);
      end
      if (k == 0) begin
        exp_q.push_back(m_ram[m_ofs]);
        scan_addr = 7'd0;
        cycle();
        tests_run++;
        if (scan_data !== exp_q[0]) begin
          tests_failed++; $display("[TB] FAIL shift_scan: got %h required %h", scan_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_clear_abort();
    logic err;
    int   n;
    bus_write(1'b0, 8'h01, err);
    repeat (50) cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    for (int i = 0; i < 50; i++) m_ram[i] = FILL;
    model_reset();
    tests_run++;
    if (busy !== 1'b0 || ac !== m_ac || cmd_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_state: got busy %b ac %h err %b required 0 %h 0", busy, ac, cmd_err, m_ac);
    end
    scan_all("abort_ddram");
    command(1'b0, 8'h85, err, n);
    tests_run++;
    if (err !== 1'b0 || n !== BUSY || ac !== m_ac) begin
      tests_failed++;
      $display("[TB] FAIL abort_idle: got err %b len %0d ac %h required 0 %0d %h", err, n, ac, BUSY, m_ac);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus_if.lcd_data_i = '0;
    bus_if.lcd_rs = 1'b0;
    bus_if.lcd_rw = 1'b0;
    bus_if.lcd_en = 1'b0;
    for (int i = 0; i < 128; i++) m_ram[i] = '0;
    test_reset();
    test_init();
    test_data_write();
    test_wrap();
    test_back_to_back();
    test_data_read();
    test_cursor_move();
    test_shift();
    test_clear_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
